// File: rtl/det_pkg.sv
// rtl/det_pkg.sv - shared defaults and slot state type for det_window_counter
package det_pkg;

  localparam int unsigned DEF_WINDOW_LEN = 64;
  localparam int unsigned DEF_THRESH     = 8;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/det_out_slot.sv
// rtl/det_out_slot.sv - one-entry valid/ready result register with sticky overrun
module det_out_slot
  import det_pkg::*;
#(
  parameter int unsigned CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_data,
  input  logic             cnt_ready,
  output logic [CNT_W-1:0] cnt_data,
  output logic             cnt_valid,
  output logic             overrun,
  output logic             take
);

  slot_state_t      state_q, state_d;
  logic [CNT_W-1:0] data_q;
  logic             overrun_q;
  logic             drop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= SLOT_EMPTY;
      data_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take) data_q <= load_data;
      if (drop) overrun_q <= 1'b1;
    end
  end

  // A full slot only takes a new result if the old one leaves on the same edge.
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    drop    = 1'b0;
    case (state_q)
      SLOT_EMPTY: begin
        if (load) begin
          state_d = SLOT_FULL;
          take    = 1'b1;
        end
      end
      SLOT_FULL: begin
        if (load) begin
          if (cnt_ready) take = 1'b1;
          else           drop = 1'b1;
        end else if (cnt_ready) begin
          state_d = SLOT_EMPTY;
        end
      end
      default: state_d = SLOT_EMPTY;
    endcase
  end

  assign cnt_data  = data_q;
  assign cnt_valid = (state_q == SLOT_FULL);
  assign overrun   = overrun_q;

endmodule

// File: rtl/det_window_counter.sv
// rtl/det_window_counter.sv - counts detector pulses per window of enabled cycles
// Optional threshold alarm enabled by defining DET_THRESH_ALARM_EN.
module det_window_counter
  import det_pkg::*;
#(
  parameter int unsigned WINDOW_LEN = DEF_WINDOW_LEN,
  parameter int unsigned CNT_W      = $clog2(WINDOW_LEN + 1),
  parameter int unsigned THRESH     = DEF_THRESH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             det_in,
  input  logic             enable,
  output logic [CNT_W-1:0] cnt_data,
  output logic             cnt_valid,
  input  logic             cnt_ready,
  output logic             overrun,
  output logic             alarm
);

  localparam int unsigned POS_W = $clog2(WINDOW_LEN);

  logic [POS_W-1:0] pos;
  logic [CNT_W-1:0] acc;
  logic [CNT_W-1:0] result;
  logic             win_end;
  logic             slot_take;

  assign win_end = enable && (pos == POS_W'(WINDOW_LEN - 1));
  // The window-end pulse is folded into the closing window's result.
  assign result  = acc + CNT_W'(det_in);

  always_ff @(posedge clk) begin
    if (reset) begin
      pos <= '0;
      acc <= '0;
    end else if (enable) begin
      if (win_end) begin
        pos <= '0;
        acc <= '0;
      end else begin
        pos <= pos + POS_W'(1);
        acc <= result;
      end
    end
  end

  det_out_slot #(
    .CNT_W(CNT_W)
  ) u_slot (
    .clk      (clk),
    .reset    (reset),
    .load     (win_end),
    .load_data(result),
    .cnt_ready(cnt_ready),
    .cnt_data (cnt_data),
    .cnt_valid(cnt_valid),
    .overrun  (overrun),
    .take     (slot_take)
  );

`ifdef DET_THRESH_ALARM_EN
  logic alarm_q;

  // Registered alongside the slot load so it coincides with the new cnt_valid data.
  always_ff @(posedge clk) begin
    if (reset) alarm_q <= 1'b0;
    else       alarm_q <= slot_take && (32'(result) >= THRESH);
  end

  assign alarm = alarm_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{slot_take, 32'(THRESH)};
  assign alarm      = 1'b0;
`endif

endmodule

// File: doc/det_window_counter.md
# det_window_counter

Downstream consumer of the Mealy `101` sequence detector's one-cycle `out` pulses. It counts detections over a fixed window of enabled bit-clock cycles. At each window boundary it presents the total on a one-entry valid/ready output. Lost results are flagged with a sticky overrun bit, and an optional threshold alarm is available.

## Interface
- `WINDOW_LEN`, 64: enabled cycles per window; must be ≥ 2.
- `CNT_W`, `$clog2(WINDOW_LEN+1)`: count width; holds `WINDOW_LEN` without saturation.
- `THRESH`, 8: alarm threshold; used only with `DET_THRESH_ALARM_EN`.
- `clk`, input, 1: single clock; all logic on its rising edge.
- `reset`, input, 1: synchronous, active-high.
- `det_in`, input, 1: detection pulse, wired to the detector's `out`.
- `enable`, input, 1: qualifies `det_in` and advances the window position.
- `cnt_data`, output, `CNT_W`: detection count of the completed window.
- `cnt_valid`, output, 1: `cnt_data` is valid.
- `cnt_ready`, input, 1: consumer accepts the result.
- `overrun`, output, 1: sticky; set when a completed window's result was dropped.
- `alarm`, output, 1: threshold alarm pulse.

## Operation
- Internal `pos` (0..`WINDOW_LEN`-1) and `acc` (`CNT_W` bits). Both hold when `enable`=0; `det_in` is ignored while `enable`=0.
- With `enable`=1 and `pos` < `WINDOW_LEN`-1:
  - `pos`+1.
  - `acc` += `det_in`.
- With `enable`=1 and `pos` = `WINDOW_LEN`-1 (window end):
  - `result` = `acc` + `det_in`.
  - `pos` ← 0, `acc` ← 0.
- Output slot FSM has two states, EMPTY and FULL:
  - EMPTY → FULL on window end: `cnt_data` ← `result`.
  - FULL & `cnt_valid` & `cnt_ready`, no window end → EMPTY.
  - FULL, window end & `cnt_ready`=1 → stays FULL with the new `result` loaded; no overrun.
  - FULL, window end & `cnt_ready`=0 → new `result` dropped. `cnt_data` is unchanged and `overrun` ← 1.
- `overrun` clears only on `reset`.
- Arithmetic never wraps: at most `WINDOW_LEN` increments per window.

## Timing
- Reset values: `cnt_data`=0, `cnt_valid`=0, `overrun`=0, `alarm`=0, `pos`=0, `acc`=0, slot EMPTY.
- Latency: `cnt_valid` rises on the cycle after the window-end cycle (registered output).
- While `cnt_valid`=1 and `cnt_ready`=0, `cnt_data` is held stable.
- `cnt_valid` never drops without acceptance, except on `reset`.
- `cnt_ready` is ignored while `cnt_valid`=0.
- Reset mid-window discards the partial `acc` and any pending result; the next window starts at `pos`=0 on the first enabled cycle after `reset` deasserts.
- A `det_in` pulse on the window-end cycle counts toward the closing window, not the next one.

## Configuration
- `DET_THRESH_ALARM_EN` defined:
  - `alarm` is a one-cycle pulse, registered, asserted in the same cycle `cnt_valid` presents a newly loaded `result` ≥ `THRESH`.
  - A dropped (overrun) result never raises `alarm`.
- Not defined: `alarm` port remains and is tied to 0.

## Structure
- Package `det_pkg`:
  - default `WINDOW_LEN` and `THRESH` constants.
  - `slot_state_t` enum {`SLOT_EMPTY`, `SLOT_FULL`}.
- Sub-module `det_out_slot`: the one-entry valid/ready register with overrun detect, parameterised on `CNT_W`.
- Window position/accumulator stays in the top module.

## Test plan
All scenarios use `WINDOW_LEN`=8, `THRESH`=3.
- `enable`=1, `det_in` pulses at `pos` 2 and 5, `cnt_ready`=1 → `cnt_valid` one cycle after `pos`=7, `cnt_data`=2, accepted, then `cnt_valid`=0.
- `det_in`=1 for a whole window → `cnt_data`=8 (no wrap); next window all 0 → `cnt_data`=0.
- `cnt_ready`=0 across two window ends → first value held stable, second dropped, `overrun`=1 until `reset`.
- `cnt_ready`=1 exactly on the next window-end cycle → new value loaded, `cnt_valid` stays high, `overrun`=0.
- `enable`=0 for 3 cycles mid-window with `det_in`=1 → not counted; window end delayed by 3 cycles.
- `reset` at `pos`=4 with `acc`=3 → all outputs 0; next window counts from 0. With `DET_THRESH_ALARM_EN`, 3 pulses → `alarm` high one cycle with `cnt_valid`; without the macro → `alarm` stays 0.
